cpu_datapath: RTL and testbench

Register-and-ALU datapath for the 8-bit accumulator CPU, sitting directly downstream of the phase-decoding controller and driving the memory interface. It owns the phase counter, program counter, instruction register, accumulator, ALU and address mux. It feeds `phase`, `opcode` and `zero` back to the controller and executes the nine control strobes the controller returns each cycle.

---
 rtl/cpu_datapath_if.sv | 28 ++
 rtl/cpu_datapath.sv | 105 ++++++++++
 tb/tb_cpu_datapath.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_datapath_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// cpu_datapath_if : memory bus between the CPU datapath (master) and memory.
// Rev 1.0
// ============================================================================
interface cpu_datapath_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5
);
  logic [AWIDTH-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DWIDTH-1:0] mem_rdata;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_wdata_en;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata, mem_wdata_en,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata, mem_wdata_en,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/cpu_datapath.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// cpu_datapath : phase counter, PC, IR, AC, ALU and address mux of the 8-bit
// accumulator CPU. Optional macro CPU_DATAPATH_CARRY_EN adds an ADD carry flag.
// Rev 1.0
// ============================================================================
module cpu_datapath #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5
) (
  input  wire logic        clk,
  input  wire logic        rst_,
  input  wire logic        sel,
  input  wire logic        rd,
  input  wire logic        ld_ir,
  input  wire logic        halt,
  input  wire logic        inc_pc,
  input  wire logic        ld_ac,
  input  wire logic        wr,
  input  wire logic        ld_pc,
  input  wire logic        data_e,
  output logic [2:0]       phase,
  output logic [2:0]       opcode,
  output logic             zero,
  output logic             halted,
  cpu_datapath_if.master   mem
`ifdef CPU_DATAPATH_CARRY_EN
  , output logic           carry
`endif
);

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;

  localparam logic [AWIDTH-1:0] PC_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

  logic [DWIDTH-1:0] ir;
  logic [DWIDTH-1:0] ac;
  logic [AWIDTH-1:0] pc;
  logic [DWIDTH-1:0] alu;
  logic [DWIDTH-1:0] add_res;

  assign opcode = ir[DWIDTH-1:AWIDTH];
  assign zero   = (ac == '0);

  assign mem.mem_addr     = sel ? pc : ir[AWIDTH-1:0];
  assign mem.mem_rd       = rd & ~halted;
  assign mem.mem_wr       = wr & ~halted;
  assign mem.mem_wdata    = data_e ? ac : '0;
  assign mem.mem_wdata_en = data_e & ~halted;

`ifdef CPU_DATAPATH_CARRY_EN
  logic [DWIDTH:0] sum;
  assign sum     = {1'b0, ac} + {1'b0, mem.mem_rdata};
  assign add_res = sum[DWIDTH-1:0];
`else
  assign add_res = ac + mem.mem_rdata;
`endif

  always_comb begin
    alu = ac;
    case (opcode)
      OP_ADD:  alu = add_res;
      OP_AND:  alu = ac & mem.mem_rdata;
      OP_XOR:  alu = ac ^ mem.mem_rdata;
      OP_LDA:  alu = mem.mem_rdata;
      default: alu = ac;
    endcase
  end

  // halt on an edge lets that edge's loads finish; only later edges are gated
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      phase  <= 3'd0;
      pc     <= '0;
      ir     <= '0;
      ac     <= '0;
      halted <= 1'b0;
    end else begin
      if (!halted) begin
        phase <= phase + 3'd1;
        if (ld_ir) ir <= mem.mem_rdata;
        if (ld_pc)       pc <= ir[AWIDTH-1:0];
        else if (inc_pc) pc <= pc + PC_ONE;
        if (ld_ac) ac <= alu;
      end
      if (halt) halted <= 1'b1;
    end
  end

`ifdef CPU_DATAPATH_CARRY_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      carry <= 1'b0;
    end else if (!halted && ld_ac) begin
      carry <= (opcode == OP_ADD) ? sum[DWIDTH] : 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_datapath.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_cpu_datapath : directed programs run through a reference controller;
// expectations are queued by the stimulus and checked by a separate monitor.
// ============================================================================
module tb_cpu_datapath;
  localparam int DW = 8;
  localparam int AW = 5;

  localparam int S_PHASE = 0, S_PC = 1, S_AC = 2, S_IR = 3, S_ZERO = 4, S_HALT = 5,
                 S_ADDR = 6, S_RD = 7, S_WR = 8, S_WEN = 9, S_WDATA = 10,
                 S_CARRY = 11, S_MEM10 = 12, S_OPC = 13;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  logic sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e;
  logic [2:0] phase, opcode;
  logic zero, halted;
`ifdef CPU_DATAPATH_CARRY_EN
  logic carry;
`endif

  cpu_datapath_if #(.DWIDTH(DW), .AWIDTH(AW)) mem_if ();

  cpu_datapath #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk    (clk),
    .rst_   (rst_),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .halt   (halt),
    .inc_pc (inc_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .phase  (phase),
    .opcode (opcode),
    .zero   (zero),
    .halted (halted),
    .mem    (mem_if)
`ifdef CPU_DATAPATH_CARRY_EN
    , .carry (carry)
`endif
  );

  // memory: zero-latency read, write at the edge ending a wr cycle
  logic [7:0] mem [32];
  logic [7:0] img [32];
  logic       load_req = 1'b0;

  assign mem_if.mem_rdata = mem[mem_if.mem_addr];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 32; i++) mem[i] <= img[i];
    end else if (mem_if.mem_wr && mem_if.mem_wdata_en) begin
      mem[mem_if.mem_addr] <= mem_if.mem_wdata;
    end
  end

  // reference controller; manual mode overrides every strobe
  logic       manual = 1'b0;
  logic [8:0] man    = 9'd0;
  logic [8:0] ctl;
  logic       aluop;

  always_comb begin
    ctl   = 9'd0;
    aluop = (opcode >= 3'd2) && (opcode <= 3'd5);
    if (manual) begin
      ctl = man;
    end else begin
      // bit order: sel rd ld_ir halt inc_pc ld_ac wr ld_pc data_e
      case (phase)
        3'd0: ctl = 9'b1_0_0_0_0_0_0_0_0;
        3'd1: ctl = 9'b1_1_0_0_0_0_0_0_0;
        3'd2: ctl = 9'b1_1_1_0_0_0_0_0_0;
        3'd3: ctl = 9'b1_1_1_0_0_0_0_0_0;
        3'd4: ctl = {3'b000, (opcode == 3'd0), 1'b1, 4'b0000};
        3'd5: ctl = {1'b0, aluop, 7'd0};
        3'd6: ctl = {1'b0, aluop, 2'b00, (opcode == 3'd1) && zero, 2'b00,
                     (opcode == 3'd7), (opcode == 3'd6)};
        default: ctl = {1'b0, aluop, 3'b000, aluop, (opcode == 3'd6),
                        (opcode == 3'd7), (opcode == 3'd6)};
      endcase
    end
  end

  assign {sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e} = ctl;

  // scoreboard
  typedef struct {
    int         cyc;
    int         sig;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int   cycle   = 0;
  int   n_check = 0;
  int   n_fail  = 0;
  int   st      = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [7:0] actual(int sig);
    case (sig)
      S_PHASE: return {5'd0, phase};
      S_PC:    return {3'd0, dut.pc};
      S_AC:    return dut.ac;
      S_IR:    return dut.ir;
      S_ZERO:  return {7'd0, zero};
      S_HALT:  return {7'd0, halted};
      S_ADDR:  return {3'd0, mem_if.mem_addr};
      S_RD:    return {7'd0, mem_if.mem_rd};
      S_WR:    return {7'd0, mem_if.mem_wr};
      S_WEN:   return {7'd0, mem_if.mem_wdata_en};
      S_WDATA: return mem_if.mem_wdata;
`ifdef CPU_DATAPATH_CARRY_EN
      S_CARRY: return {7'd0, carry};
`endif
      S_MEM10: return mem[16];
      S_OPC:   return {5'd0, opcode};
      default: return 8'h00;
    endcase
  endfunction

  initial begin : monitor
    exp_t       e;
    logic [7:0] a;
    forever begin
      @(negedge clk or negedge rst_);
      #1;
      while (sbq.size() > 0 && sbq[0].cyc <= cycle) begin
        e = sbq.pop_front();
        a = actual(e.sig);
        n_check++;
        if (e.cyc != cycle || a !== e.val) begin
          n_fail++;
          $display("FAIL %s: actual %0h, required %0h (cycle %0d, due %0d)",
                   e.name, a, e.val, cycle, e.cyc);
        end
      end
    end
  end

  task automatic chk(int sig, logic [7:0] val, string name);
    sbq.push_back('{cycle, sig, val, name});
  endtask

  task automatic to_step(int s);
    while (st < s) begin
      @(negedge clk);
      st++;
    end
  endtask

  // load image during reset, release at a negedge: step 0 is phase 0
  task automatic start_program();
    manual   = 1'b0;
    load_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    load_req = 1'b0;
    rst_     = 1'b1;
    st       = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin : stimulus
    // ---- asynchronous reset in the middle of phase 5 ----
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    img[0] = 8'hBE; img[1] = 8'hE6; img[6] = 8'h7F;
    img[5'h1E] = 8'h3C; img[5'h1F] = 8'hFF;
    start_program();
    to_step(16); chk(S_PC, 8'h06, "jmp_to_6");
    to_step(21); chk(S_PHASE, 8'd5, "pre_rst_phase");
    chk(S_PC, 8'h07, "pre_rst_pc"); chk(S_AC, 8'h3C, "pre_rst_ac");
    #2;
    rst_ = 1'b0;
    chk(S_PHASE, 8'd0, "rst_phase"); chk(S_PC, 8'h00, "rst_pc");
    chk(S_AC, 8'h00, "rst_ac"); chk(S_IR, 8'h00, "rst_ir");
    chk(S_ZERO, 8'd1, "rst_zero"); chk(S_HALT, 8'd0, "rst_halted");

    // ---- main program ----
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    img[0] = 8'hBD; img[1] = 8'h4A; img[2] = 8'hAC; img[3] = 8'h4D;
    img[4] = 8'h6E; img[5] = 8'h8F; img[6] = 8'h20; img[8] = 8'hFF;
    img[5'h0A] = 8'h05; img[5'h0C] = 8'hF0; img[5'h0D] = 8'h20;
    img[5'h0E] = 8'h30; img[5'h0F] = 8'h10;
    img[5'h11] = 8'hBC; img[5'h12] = 8'hD0; img[5'h13] = 8'h00; img[5'h14] = 8'h77;
    img[5'h1C] = 8'h5A; img[5'h1D] = 8'h03; img[5'h1F] = 8'hF1;
    #20;
    start_program();

    to_step(8);  chk(S_AC, 8'h03, "lda_ac"); chk(S_ADDR, 8'h01, "fetch_addr_pc");
    to_step(11); chk(S_IR, 8'h4A, "ir_load"); chk(S_OPC, 8'd2, "opcode_add");
    to_step(12); chk(S_PC, 8'h01, "pc_before_inc");
    to_step(13); chk(S_PC, 8'h02, "pc_after_inc"); chk(S_ADDR, 8'h0A, "operand_addr_p5");
    to_step(15); chk(S_ADDR, 8'h0A, "operand_addr_p7");
    to_step(16); chk(S_AC, 8'h08, "add_ac"); chk(S_ZERO, 8'd0, "add_zero");
    to_step(32); chk(S_AC, 8'h10, "add_ovf_ac"); chk(S_ZERO, 8'd0, "add_ovf_zero");
`ifdef CPU_DATAPATH_CARRY_EN
    chk(S_CARRY, 8'd1, "add_ovf_carry");
`endif
    to_step(40); chk(S_AC, 8'h10, "and_ac");
`ifdef CPU_DATAPATH_CARRY_EN
    chk(S_CARRY, 8'd0, "and_clears_carry");
`endif
    to_step(48); chk(S_AC, 8'h00, "xor_ac"); chk(S_ZERO, 8'd1, "xor_zero");
    chk(S_PC, 8'h06, "skz_start_pc");
    to_step(56); chk(S_PC, 8'h08, "skz_double_inc");
    to_step(64); chk(S_PC, 8'h1F, "jmp_1f");
    to_step(69); chk(S_PC, 8'h00, "pc_wrap");
    to_step(72); chk(S_PC, 8'h11, "jmp_11");
    to_step(80); chk(S_AC, 8'h5A, "lda_5a");
    to_step(84); chk(S_WEN, 8'd0, "sto_wen_p4"); chk(S_WR, 8'd0, "sto_wr_p4");
    to_step(86); chk(S_WEN, 8'd1, "sto_wen_p6"); chk(S_WDATA, 8'h5A, "sto_wdata_p6");
    chk(S_WR, 8'd0, "sto_wr_p6"); chk(S_ADDR, 8'h10, "sto_addr_p6");
    to_step(87); chk(S_WEN, 8'd1, "sto_wen_p7"); chk(S_WR, 8'd1, "sto_wr_p7");
    chk(S_ADDR, 8'h10, "sto_addr_p7"); chk(S_WDATA, 8'h5A, "sto_wdata_p7");
    to_step(88); chk(S_MEM10, 8'h5A, "sto_mem"); chk(S_WDATA, 8'h00, "wdata_idle");
    to_step(92); chk(S_HALT, 8'd0, "halt_not_yet");
    to_step(93); chk(S_HALT, 8'd1, "halted_set"); chk(S_PHASE, 8'd5, "halt_phase");
    chk(S_PC, 8'h14, "halt_pc");

    // every strobe forced high while halted: nothing may move or reach memory
    manual = 1'b1;
    man    = 9'h1FF;
    to_step(100); chk(S_RD, 8'd0, "halt_rd"); chk(S_WR, 8'd0, "halt_wr");
    chk(S_WEN, 8'd0, "halt_wen");
    to_step(113); chk(S_PHASE, 8'd5, "frozen_phase"); chk(S_PC, 8'h14, "frozen_pc");
    chk(S_AC, 8'h5A, "frozen_ac"); chk(S_IR, 8'h00, "frozen_ir");
    chk(S_HALT, 8'd1, "still_halted");
    #2;
    rst_ = 1'b0;
    chk(S_HALT, 8'd0, "rst_clears_halt"); chk(S_PHASE, 8'd0, "rst_phase_after_halt");
    manual = 1'b0;

    repeat (3) @(negedge clk);
    #3;
    if (sbq.size() != 0) begin
      n_check++;
      n_fail++;
      $display("FAIL drain: %0d expectations unchecked, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
